// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES hash words from shared memory, tracks the minimum and its index,
// then writes a {found flag, min hash} record back through the same memory port.
module hash_result_scanner #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] hash_out_addr,
    input  logic [ADDR_W-1:0] result_addr,
    input  logic [31:0]       target,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [31:0]       memory_write_data,
    input  logic [31:0]       memory_read_data,
    output logic              found,
    output logic [7:0]        best_nonce,
    output logic [31:0]       min_hash
);

    localparam logic [7:0] NumN    = 8'(NUM_NONCES);
    localparam logic [7:0] LastIdx = 8'(NUM_NONCES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWriteFlag,
        StWriteMin
    } state_e;

    state_e      state_q;
    logic [7:0]  issue_cnt_q;
    logic [7:0]  cap_cnt_q;
    logic [7:0]  run_idx_q;
    logic [31:0] run_min_q;

    logic        capture;
    logic        last_capture;
    logic        word_lt;
    logic [31:0] next_min;
    logic [7:0]  next_idx;

    // Read data for the first address only becomes valid once one address has been issued
    // past it, so capture trails the issue counter by one cycle.
    always_comb begin
        capture      = (state_q == StRead) && (issue_cnt_q != 8'd0);
        last_capture = capture && (cap_cnt_q == LastIdx);
        word_lt      = memory_read_data < run_min_q;
        next_min     = (capture && word_lt) ? memory_read_data : run_min_q;
        next_idx     = (capture && word_lt) ? cap_cnt_q : run_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            issue_cnt_q       <= 8'd0;
            cap_cnt_q         <= 8'd0;
            run_idx_q         <= 8'd0;
            run_min_q         <= 32'd0;
            mem_we            <= 1'b0;
            memory_addr       <= '0;
            memory_write_data <= 32'd0;
            found             <= 1'b0;
            best_nonce        <= 8'd0;
            min_hash          <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        memory_addr <= hash_out_addr;
                        issue_cnt_q <= 8'd0;
                        cap_cnt_q   <= 8'd0;
                        run_min_q   <= 32'hFFFF_FFFF;
                        run_idx_q   <= 8'd0;
                        state_q     <= StRead;
                    end
                end
                StRead: begin
                    if (issue_cnt_q < NumN) begin
                        issue_cnt_q <= issue_cnt_q + 8'd1;
                    end
                    // Stop at the last hash word so no address past the block is read.
                    if (issue_cnt_q < LastIdx) begin
                        memory_addr <= memory_addr + 1'b1;
                    end
                    if (capture) begin
                        cap_cnt_q <= cap_cnt_q + 8'd1;
                        run_min_q <= next_min;
                        run_idx_q <= next_idx;
                    end
                    if (last_capture) begin
                        memory_addr       <= result_addr;
                        memory_write_data <= {31'b0, next_min < target};
                        mem_we            <= 1'b1;
                        state_q           <= StWriteFlag;
                    end
                end
                StWriteFlag: begin
                    found             <= run_min_q < target;
                    best_nonce        <= run_idx_q;
                    min_hash          <= run_min_q;
                    memory_addr       <= result_addr + 1'b1;
                    memory_write_data <= run_min_q;
                    state_q           <= StWriteMin;
                end
                StWriteMin: begin
                    mem_we  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign done    = (state_q == StIdle);
    assign mem_clk = clk;

endmodule
